// File: rtl/cmd_proc_route_if.sv
// Command/ID/motion signal bundle between the UART/ID-reader front end and cmd_proc_route.
interface cmd_proc_route_if #(
    parameter int unsigned ID_W  = 6,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic            cmd_rdy;
    logic [ID_W+1:0] cmd;
    logic            clr_cmd_rdy;
    logic            ID_vld;
    logic [ID_W-1:0] ID;
    logic            clr_ID_vld;
    logic            Ok2Move;
    logic            go;
    logic            in_transit;
    logic [ID_W-1:0] dest_ID;
    logic [CW-1:0]   q_count;
    logic            arrived;
    logic            cmd_err;
    logic            buzz;
    logic            buzz_n;

    modport master (
        output cmd_rdy, cmd, ID_vld, ID, Ok2Move,
        input  clr_cmd_rdy, clr_ID_vld, go, in_transit, dest_ID, q_count,
               arrived, cmd_err, buzz, buzz_n
    );

    modport slave (
        input  cmd_rdy, cmd, ID_vld, ID, Ok2Move,
        output clr_cmd_rdy, clr_ID_vld, go, in_transit, dest_ID, q_count,
               arrived, cmd_err, buzz, buzz_n
    );
endinterface

// File: rtl/cmd_proc_route.sv
// Multi-stop route command processor: GO/ADD/STOP route FIFO, station matching,
// motion gating and complementary piezo alarm while obstructed in transit.
module cmd_proc_route #(
    parameter int unsigned ID_W     = 6,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned BUZZ_DIV = 12500
) (
    input  logic             clk,
    input  logic             rst,
    cmd_proc_route_if.slave  bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned DW = $clog2(BUZZ_DIV);

    localparam logic [1:0] OP_STOP = 2'b00;
    localparam logic [1:0] OP_GO   = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_RSV  = 2'b11;

    typedef enum logic {IDLE, TRANSIT} state_e;

    state_e          state_q, state_d;
    logic [ID_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [ID_W-1:0] dest_q, dest_d;
    logic            arrived_q, arrived_d;
    logic            cmd_err_q, cmd_err_d;
    logic [DW-1:0]   div_q, div_d;
    logic            buzz_q, buzz_d, buzz_n_q, buzz_n_d;

    logic [1:0]      op;
    logic [ID_W-1:0] cmd_id;
    logic            is_go, is_stop, is_add, is_rsv, flush, pop, push, full;
    logic            piezo_en_c;
    logic [PW-1:0]   rd_nxt;

    assign op     = bus.cmd[ID_W+1:ID_W];
    assign cmd_id = bus.cmd[ID_W-1:0];
    assign is_go  = bus.cmd_rdy && (op == OP_GO);
    assign is_stop= bus.cmd_rdy && (op == OP_STOP);
    assign is_add = bus.cmd_rdy && (op == OP_ADD);
    assign is_rsv = bus.cmd_rdy && (op == OP_RSV);
    assign flush  = is_go || is_stop;
    assign full   = (count_q == CW'(DEPTH));
    assign rd_nxt = rd_ptr_q + PW'(1);

    // GO/STOP override a same-cycle station hit; a hit frees a slot for a same-cycle ADD
    assign pop  = bus.ID_vld && (state_q == TRANSIT) && (bus.ID == mem_q[rd_ptr_q]) && !flush;
    assign push = is_add && (!full || pop);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state follows route occupancy after this edge
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (count_d != '0) state_d = TRANSIT;
            TRANSIT: if (count_d == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Combinational handshakes and motion gating
    always_comb begin
        bus.clr_cmd_rdy = bus.cmd_rdy;
        bus.clr_ID_vld  = bus.ID_vld;
        bus.go          = (state_q == TRANSIT) && bus.Ok2Move;
        piezo_en_c      = (state_q == TRANSIT) && !bus.Ok2Move;
    end

    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        dest_d    = dest_q;
        arrived_d = pop;
        cmd_err_d = is_rsv || (is_add && full && !pop);
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = is_go ? PW'(1) : '0;
            count_d  = is_go ? CW'(1) : '0;
            dest_d   = is_go ? cmd_id : '0;
        end else begin
            rd_ptr_d = pop  ? rd_nxt : rd_ptr_q;
            wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
            count_d  = count_q + CW'(push) - CW'(pop);
            // Head after this edge; the entry behind the head may be the one being pushed
            if (pop)
                dest_d = (count_q == CW'(1)) ? (push ? cmd_id : '0) : mem_q[rd_nxt];
            else if (push && count_q == '0)
                dest_d = cmd_id;
        end
    end

    // Piezo divider: squelched to 0/0 whenever not obstructed
    always_comb begin
        div_d    = '0;
        buzz_d   = 1'b0;
        buzz_n_d = 1'b0;
        if (piezo_en_c) begin
            if (div_q == DW'(BUZZ_DIV - 1)) begin
                div_d  = '0;
                buzz_d = !buzz_q;
            end else begin
                div_d  = div_q + DW'(1);
                buzz_d = buzz_q;
            end
            buzz_n_d = !buzz_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            dest_q    <= '0;
            arrived_q <= 1'b0;
            cmd_err_q <= 1'b0;
            div_q     <= '0;
            buzz_q    <= 1'b0;
            buzz_n_q  <= 1'b0;
        end else begin
            if (is_go)     mem_q[0]        <= cmd_id;
            else if (push) mem_q[wr_ptr_q] <= cmd_id;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            dest_q    <= dest_d;
            arrived_q <= arrived_d;
            cmd_err_q <= cmd_err_d;
            div_q     <= div_d;
            buzz_q    <= buzz_d;
            buzz_n_q  <= buzz_n_d;
        end
    end

    assign bus.in_transit = (state_q == TRANSIT);
    assign bus.dest_ID    = dest_q;
    assign bus.q_count    = count_q;
    assign bus.arrived    = arrived_q;
    assign bus.cmd_err    = cmd_err_q;
    assign bus.buzz       = buzz_q;
    assign bus.buzz_n     = buzz_n_q;
endmodule

// File: tb/tb_cmd_proc_route.sv
// Directed bench for cmd_proc_route: route commands, station matching, FIFO wrap,
// collisions, piezo alarm timing and asynchronous reset.
module tb_cmd_proc_route;
    localparam int unsigned ID_W     = 6;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned BUZZ_DIV = 12500;

    localparam logic [1:0] OP_STOP = 2'b00;
    localparam logic [1:0] OP_GO   = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_RSV  = 2'b11;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [ID_W-1:0] exp_q[$];

    cmd_proc_route_if #(.ID_W(ID_W), .DEPTH(DEPTH)) bus ();

    cmd_proc_route #(.ID_W(ID_W), .DEPTH(DEPTH), .BUZZ_DIV(BUZZ_DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [ID_W-1:0] id);
        bus.cmd_rdy = 1'b1;
        bus.cmd     = {op, id};
        #1 check("clr_cmd_rdy", 32'(bus.clr_cmd_rdy), 32'd1);
        step();
        bus.cmd_rdy = 1'b0;
    endtask

    task automatic send_id(input logic [ID_W-1:0] id);
        bus.ID_vld = 1'b1;
        bus.ID     = id;
        #1 check("clr_ID_vld", 32'(bus.clr_ID_vld), 32'd1);
        step();
        bus.ID_vld = 1'b0;
    endtask

    task automatic send_both(input logic [1:0] op, input logic [ID_W-1:0] cid,
                             input logic [ID_W-1:0] id);
        bus.cmd_rdy = 1'b1;
        bus.cmd     = {op, cid};
        bus.ID_vld  = 1'b1;
        bus.ID      = id;
        step();
        bus.cmd_rdy = 1'b0;
        bus.ID_vld  = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.cmd_rdy = 1'b0; bus.cmd = '0; bus.ID_vld = 1'b0; bus.ID = '0; bus.Ok2Move = 1'b0;
        step(); step();
        check("rst_in_transit", 32'(bus.in_transit), 32'd0);
        check("rst_q_count", 32'(bus.q_count), 32'd0);
        check("rst_dest", 32'(bus.dest_ID), 32'd0);
        check("rst_buzz_pair", 32'({bus.buzz, bus.buzz_n, bus.arrived, bus.cmd_err, bus.go}), 32'd0);
        rst = 1'b0;
        bus.Ok2Move = 1'b1;
        step();

        // GO 0x15 via raw cmd 0x55
        send_cmd(OP_GO, 6'h15);
        check("go_in_transit", 32'(bus.in_transit), 32'd1);
        check("go_dest", 32'(bus.dest_ID), 32'h15);
        check("go_q_count", 32'(bus.q_count), 32'd1);
        check("go_go", 32'(bus.go), 32'd1);

        // Multi-stop route; only the head matches
        send_cmd(OP_GO, 6'h03);
        send_cmd(OP_ADD, 6'h07);
        send_cmd(OP_ADD, 6'h09);
        check("route3_q", 32'(bus.q_count), 32'd3);
        send_id(6'h07);
        check("nonhead_arrived", 32'(bus.arrived), 32'd0);
        check("nonhead_q", 32'(bus.q_count), 32'd3);
        send_id(6'h03);
        check("pop1_arrived", 32'(bus.arrived), 32'd1);
        check("pop1_dest", 32'(bus.dest_ID), 32'h07);
        check("pop1_q", 32'(bus.q_count), 32'd2);
        step();
        check("arrived_one_cycle", 32'(bus.arrived), 32'd0);
        send_id(6'h07);
        check("pop2_arrived", 32'(bus.arrived), 32'd1);
        check("pop2_dest", 32'(bus.dest_ID), 32'h09);
        send_id(6'h09);
        check("pop3_arrived", 32'(bus.arrived), 32'd1);
        check("empty_state", 32'({bus.in_transit, bus.go}), 32'd0);
        check("empty_q", 32'(bus.q_count), 32'd0);
        check("empty_dest", 32'(bus.dest_ID), 32'd0);
        send_id(6'h09);
        check("idle_id_ignored", 32'(bus.arrived), 32'd0);

        // Fill to DEPTH, then overflow ADD
        send_cmd(OP_GO, 6'h01);
        send_cmd(OP_ADD, 6'h02);
        send_cmd(OP_ADD, 6'h03);
        send_cmd(OP_ADD, 6'h04);
        exp_q = '{6'h01, 6'h02, 6'h03, 6'h04};
        check("full_q", 32'(bus.q_count), 32'd4);
        send_cmd(OP_ADD, 6'h2A);
        check("ovf_cmd_err", 32'(bus.cmd_err), 32'd1);
        check("ovf_q", 32'(bus.q_count), 32'd4);
        check("ovf_dest", 32'(bus.dest_ID), 32'h01);
        step();
        check("ovf_err_one_cycle", 32'(bus.cmd_err), 32'd0);

        // Pointer wrap: pop head then refill, six times
        for (int i = 0; i < 6; i++) begin
            send_id(exp_q[0]);
            void'(exp_q.pop_front());
            check("wrap_arrived", 32'(bus.arrived), 32'd1);
            check("wrap_dest", 32'(bus.dest_ID), 32'(exp_q[0]));
            send_cmd(OP_ADD, ID_W'(6'h30 + i));
            exp_q.push_back(ID_W'(6'h30 + i));
            check("wrap_q", 32'(bus.q_count), 32'd4);
        end

        send_cmd(OP_RSV, 6'h05);
        check("rsv_cmd_err", 32'(bus.cmd_err), 32'd1);
        check("rsv_q", 32'(bus.q_count), 32'd4);

        // ADD colliding with a matching ID on a full route
        send_both(OP_ADD, 6'h11, exp_q[0]);
        void'(exp_q.pop_front());
        exp_q.push_back(6'h11);
        check("coll_add_q", 32'(bus.q_count), 32'd4);
        check("coll_add_arrived", 32'(bus.arrived), 32'd1);
        check("coll_add_err", 32'(bus.cmd_err), 32'd0);
        check("coll_add_dest", 32'(bus.dest_ID), 32'(exp_q[0]));
        // Drain to confirm order is intact after the wrap
        for (int i = 0; i < 4; i++) begin
            check("drain_dest", 32'(bus.dest_ID), 32'(exp_q[0]));
            send_id(exp_q[0]);
            void'(exp_q.pop_front());
        end
        check("drain_empty", 32'(bus.in_transit), 32'd0);

        // Obstructed in transit: piezo toggles every BUZZ_DIV clocks
        send_cmd(OP_GO, 6'h0C);
        send_cmd(OP_ADD, 6'h0D);
        bus.Ok2Move = 1'b0;
        #1 check("obst_go", 32'(bus.go), 32'd0);
        repeat (BUZZ_DIV - 1) step();
        check("buzz_pre_toggle", 32'({bus.buzz, bus.buzz_n}), 32'b01);
        step();
        check("buzz_toggle1", 32'({bus.buzz, bus.buzz_n}), 32'b10);
        repeat (BUZZ_DIV - 1) step();
        check("buzz_hold", 32'({bus.buzz, bus.buzz_n}), 32'b10);
        step();
        check("buzz_toggle2", 32'({bus.buzz, bus.buzz_n}), 32'b01);
        bus.Ok2Move = 1'b1;
        step();
        check("buzz_squelch", 32'({bus.buzz, bus.buzz_n}), 32'b00);
        check("clear_go", 32'(bus.go), 32'd1);

        send_cmd(OP_STOP, 6'h00);
        check("stop_in_transit", 32'(bus.in_transit), 32'd0);
        check("stop_q", 32'(bus.q_count), 32'd0);

        // STOP colliding with a matching ID
        send_cmd(OP_GO, 6'h05);
        send_cmd(OP_ADD, 6'h06);
        send_both(OP_STOP, 6'h00, 6'h05);
        check("coll_stop_arrived", 32'(bus.arrived), 32'd0);
        check("coll_stop_q", 32'(bus.q_count), 32'd0);

        // Asynchronous reset mid-transit
        send_cmd(OP_GO, 6'h0A);
        bus.Ok2Move = 1'b0;
        repeat (BUZZ_DIV + 2) step();
        check("pre_rst_buzz", 32'(bus.buzz), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_outputs", 32'({bus.in_transit, bus.go, bus.arrived, bus.cmd_err,
                                   bus.buzz, bus.buzz_n}), 32'd0);
        check("arst_q", 32'(bus.q_count), 32'd0);
        check("arst_dest", 32'(bus.dest_ID), 32'd0);
        step();
        rst = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cmd_proc_route.md
Name: cmd_proc_route

Overview:
- Parametrised successor to the single-destination follower command processor.
- Accepts GO/ADD/STOP commands from the UART command path and holds a multi-stop route of station IDs in a FIFO.
- Compares ID-reader station hits against the route head and gates motion through Ok2Move.
- Drives a complementary piezo alarm while the robot is obstructed in transit.

Parameters:
- ID_W, 6: station ID width; cmd width is ID_W+2.
- DEPTH, 4: route FIFO depth, power of 2, ≥2.
- BUZZ_DIV, 12500: clocks per buzz half-period (2 kHz at 50 MHz), ≥2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- cmd_rdy  in  1  command valid from UART wrapper.
- cmd  in  ID_W+2  command; [ID_W+1:ID_W] opcode, [ID_W-1:0] station ID.
- clr_cmd_rdy  out  1  command consumed.
- ID_vld  in  1  station ID valid from ID reader.
- ID  in  ID_W  station ID read.
- clr_ID_vld  out  1  ID consumed.
- Ok2Move  in  1  path clear from proximity logic.
- go  out  1  motion enable.
- in_transit  out  1  route active.
- dest_ID  out  ID_W  current route head; 0 when route empty.
- q_count  out  $clog2(DEPTH)+1  entries in route.
- arrived  out  1  one-cycle pulse on reaching a route station.
- cmd_err  out  1  one-cycle pulse on rejected command.
- buzz, buzz_n  out  1  piezo drive pair.

Behaviour:
Reset (async, active-high):
- Route empty; state IDLE.
- in_transit, go, arrived, cmd_err, buzz, buzz_n, dest_ID and q_count all 0.

Opcodes:
- 2'b01 GO: flush route, load cmd ID as sole entry.
- 2'b10 ADD: enqueue at tail.
- 2'b00 STOP: flush route.
- 2'b11: reserved.

Command handling:
- clr_cmd_rdy is combinational: high in every cycle cmd_rdy=1, in any state.
- The command takes effect at that clock edge. Upstream drops cmd_rdy on the following cycle.
- ADD with q_count==DEPTH: command dropped, route unchanged, cmd_err pulses the next cycle.
- Reserved opcode: dropped, cmd_err pulses the next cycle.

ID handling:
- clr_ID_vld is combinational: high in every cycle ID_vld=1, in any state. Every ID is consumed.
- In TRANSIT with ID==dest_ID: head popped at the edge; arrived pulses the next cycle.
- Non-matching ID, or any ID in IDLE: ignored, no pulse.

States:
- IDLE→TRANSIT when the route becomes non-empty (GO, or ADD while empty).
- TRANSIT→IDLE when the route becomes empty (STOP, or pop of the last entry).
- in_transit is registered and equals (state==TRANSIT).

Simultaneous cmd_rdy and ID_vld:
- GO or STOP takes priority: the ID is consumed but produces no pop and no arrived pulse.
- ADD together with a matching ID: pop and push in the same edge, q_count unchanged, arrived pulses. This also applies when full, with no cmd_err.
- ADD on an empty route with a matching ID is impossible, because IDLE ignores IDs.

Outputs:
- dest_ID reflects the new head one cycle after a pop or push.
- FIFO pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.

Motion and alarm:
- go = in_transit & Ok2Move, combinational.
- piezo_en = in_transit & ~Ok2Move.
- While piezo_en: the divider counts 0..BUZZ_DIV-1, buzz toggles on wrap, buzz_n = ~buzz.
- When piezo_en is low: divider cleared, buzz=0 and buzz_n=0, so there is no DC across the piezo.
- Reset mid-operation: immediate return to reset values and route lost.

Test Plan:
- Reset, then GO id 0x15 (cmd=0x55) → clr_cmd_rdy high that cycle; next cycle in_transit=1, dest_ID=0x15, q_count=1; with Ok2Move=1, go=1.
- GO 0x03, ADD 0x07, ADD 0x09; ID_vld ID=0x07 → ignored (clr_ID_vld=1, no arrived). Then ID=0x03 → arrived pulse, dest_ID=0x07, q_count=2.
- Continuing from the previous scenario: ID=0x07, then ID=0x09 → arrived pulses each time; after the last, in_transit=0, go=0, q_count=0, dest_ID=0.
- Fill 4 entries, then ADD 0x2A → cmd_err one pulse, q_count=4, route unchanged. With DEPTH=4, 6 push/pop cycles exercise pointer wrap and keep ID order correct.
- In transit with Ok2Move=0 → buzz toggles every 12500 clocks, buzz_n=~buzz, go=0. Ok2Move=1 → buzz=buzz_n=0 the next cycle. STOP (cmd=0x00) mid-route → route flushed, in_transit=0.
- Same-cycle ADD 0x11 and matching ID on a full route → q_count stays 4, arrived=1, cmd_err=0. Same-cycle STOP and matching ID → no arrived, q_count=0. Assert rst mid-transit → all outputs 0 asynchronously.
